// File: rtl/hazard_match_pipe_pkg.sv
// Shared pipeline definitions for hazard_match_pipe and the hazard unit:
// default address sizing, Match bit positions and the per-stage enable bundle.
package hazard_match_pipe_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_PC_REG = 15;

    // Match bit positions; the hazard unit indexes Match with these same names.
    localparam int MATCH_RA1_P1M = 7;
    localparam int MATCH_RA2_P1M = 6;
    localparam int MATCH_RA1_P1W = 5;
    localparam int MATCH_RA2_P1W = 4;
    localparam int MATCH_RA1_P2M = 3;
    localparam int MATCH_RA2_P2M = 2;
    localparam int MATCH_RA2_P2W = 1;
    localparam int MATCH_RA1_P2W = 0;

    typedef struct packed {
        logic reg_write1;
        logic reg_write2;
        logic mem_to_reg;
    } stage_en_t;

    localparam int STAGE_EN_W = $bits(stage_en_t);

endpackage

// File: rtl/hazard_pipe_reg.sv
// Width-parameterised pipeline stage register with async active-low clear
// and a synchronous bubble that loads all zeros.
module hazard_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_match_pipe.sv
// Carries source/destination addresses and write enables through E, M and W
// and produces the register-dependency Match vector for the hazard unit.
module hazard_match_pipe
    import hazard_match_pipe_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PC_REG = DEF_PC_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic              UseRA1D,
    input  logic              UseRA2D,
    input  logic [ADDR_W-1:0] WA3D1,
    input  logic [ADDR_W-1:0] WA3D2,
    input  logic              RegWrite1D,
    input  logic              RegWrite2D,
    input  logic              MemtoRegD,
    input  logic              CondExE,
    input  logic              FlushE,
    output logic [7:0]        Match,
    output logic              LME,
    output logic              RegWrite1M,
    output logic              RegWrite2M,
    output logic              RegWrite1W,
    output logic              RegWrite2W
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);
    localparam int E_W = 3 + STAGE_EN_W + 4 * ADDR_W;
    localparam int M_W = STAGE_EN_W + 2 * ADDR_W;
    localparam int W_W = 2 + 2 * ADDR_W;

    logic [E_W-1:0]    e_d, e_q;
    logic [M_W-1:0]    m_d, m_q;
    logic [W_W-1:0]    w_d, w_q;

    stage_en_t         en_d, en_e, en_m_d, en_m;
    logic              valid_e, use_ra1_e, use_ra2_e, live_e;
    logic [ADDR_W-1:0] ra1_e, ra2_e, wa1_e, wa2_e;
    logic [ADDR_W-1:0] wa1_m, wa2_m, wa1_w, wa2_w;
    logic              rw1_w, rw2_w;

    // E stage: FlushE zeroes the whole word, so a bubble has valid and every enable low.
    assign en_d = '{reg_write1: RegWrite1D, reg_write2: RegWrite2D, mem_to_reg: MemtoRegD};
    assign e_d  = {1'b1, UseRA1D, UseRA2D, en_d, RA1D, RA2D, WA3D1, WA3D2};

    hazard_pipe_reg #(.W(E_W)) u_reg_e (
        .clk    (clk),
        .reset  (reset),
        .bubble (FlushE),
        .d      (e_d),
        .q      (e_q)
    );

    assign {valid_e, use_ra1_e, use_ra2_e, en_e, ra1_e, ra2_e, wa1_e, wa2_e} = e_q;

    // Enables only survive into M if the instruction is real and its condition passed.
    assign live_e = CondExE & valid_e;

    always_comb begin
        en_m_d            = '0;
        en_m_d.reg_write1 = en_e.reg_write1 & live_e;
        en_m_d.reg_write2 = en_e.reg_write2 & live_e;
        en_m_d.mem_to_reg = en_e.mem_to_reg & live_e;
    end

    assign m_d = {en_m_d, wa1_e, wa2_e};

    hazard_pipe_reg #(.W(M_W)) u_reg_m (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (m_d),
        .q      (m_q)
    );

    assign {en_m, wa1_m, wa2_m} = m_q;

    assign w_d = {en_m.reg_write1, en_m.reg_write2, wa1_m, wa2_m};

    hazard_pipe_reg #(.W(W_W)) u_reg_w (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (w_d),
        .q      (w_q)
    );

    assign {rw1_w, rw2_w, wa1_w, wa2_w} = w_q;

    function automatic logic src_hit(
        input logic              use_src,
        input logic [ADDR_W-1:0] ra,
        input logic [ADDR_W-1:0] wa,
        input logic              we
    );
        return valid_e & use_src & we & (ra == wa) & (ra != PC_ADDR);
    endfunction

    always_comb begin
        Match                = '0;
        Match[MATCH_RA1_P1M] = src_hit(use_ra1_e, ra1_e, wa1_m, en_m.reg_write1);
        Match[MATCH_RA2_P1M] = src_hit(use_ra2_e, ra2_e, wa1_m, en_m.reg_write1);
        Match[MATCH_RA1_P1W] = src_hit(use_ra1_e, ra1_e, wa1_w, rw1_w);
        Match[MATCH_RA2_P1W] = src_hit(use_ra2_e, ra2_e, wa1_w, rw1_w);
        Match[MATCH_RA1_P2M] = src_hit(use_ra1_e, ra1_e, wa2_m, en_m.reg_write2);
        Match[MATCH_RA2_P2M] = src_hit(use_ra2_e, ra2_e, wa2_m, en_m.reg_write2);
        Match[MATCH_RA2_P2W] = src_hit(use_ra2_e, ra2_e, wa2_w, rw2_w);
        Match[MATCH_RA1_P2W] = src_hit(use_ra1_e, ra1_e, wa2_w, rw2_w);
    end

    assign LME        = en_m.mem_to_reg & en_m.reg_write1;
    assign RegWrite1M = en_m.reg_write1;
    assign RegWrite2M = en_m.reg_write2;
    assign RegWrite1W = rw1_w;
    assign RegWrite2W = rw2_w;

endmodule
